world_mem_arbiter: RTL and testbench
====================================

Name: world_mem_arbiter

Overview:
- Shares the single-port world-map BRAM between three users:
  - the VGA pixel fetch, which must never miss a slot;
  - the physics engine, which reads for wall collision;
  - the level loader, which reads and writes map cells.
- Sits between the display timing generator/colorizer path and the game logic.
- Converts the current (pixel_row, pixel_column) into a world cell address on every pixel tick and returns world_pixel to the colorizer.
- Hands all remaining memory cycles to the game requesters by round-robin.

Parameters:
- MAP_W, 160, world map width in cells (one cell = 4x4 screen pixels)
- MAP_H, 120, world map height in cells
- ADDR_W, 15, memory address width; must satisfy 2^ADDR_W >= MAP_W*MAP_H
- MEM_LAT, 1, BRAM read latency in cycles from mem_en to mem_rdata valid (1 or 2)

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  asynchronous, active-low reset
- pixel_tick  in  1  one-cycle strobe per 25 MHz pixel, spaced at least MEM_LAT+2 cycles apart
- video_on  in  1  display-active flag from the timing generator
- pixel_row  in  10  current screen row, 0..479
- pixel_column  in  10  current screen column, 0..639
- world_pixel  out  8  map cell value for the last fetched pixel
- phy_req  in  1  physics read request
- phy_addr  in  ADDR_W  physics read address
- phy_gnt  out  1  request accepted this cycle
- phy_rvalid  out  1  phy_rdata valid pulse
- phy_rdata  out  8  physics read data
- ld_req  in  1  loader request
- ld_we  in  1  loader write when 1, read when 0
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  8  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  ld_rdata valid pulse
- ld_rdata  out  8  loader read data
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  8  BRAM write data
- mem_rdata  in  8  BRAM read data

Behaviour:
- Reset: all outputs 0; round-robin pointer selects phy; read-tag pipeline cleared. Reset mid-operation drops any in-flight read, so no rvalid is emitted for it.
- Video slot:
  - Condition: the cycle where pixel_tick=1 and video_on=1.
  - Cell address = (pixel_row>>2)*MAP_W + (pixel_column>>2). Computed combinationally with zero-extension to ADDR_W; for MAP_W=160 this is (r<<7)+(r<<5)+c.
  - Coordinates outside 640x480 with video_on=1 are clamped to the last cell.
  - The video slot has absolute priority. No game grant is issued in that cycle.
- Game slot: any other cycle, including tick cycles with video_on=0.
  - If exactly one of phy_req/ld_req is high, it is granted.
  - If both are high, the requester selected by the pointer is granted, and the pointer then toggles to the other requester.
  - The pointer only changes on a contested grant.
- gnt is combinational and asserts in the accepting cycle. The requester must hold req/addr/we/wdata stable until gnt is seen, and may change them the cycle after gnt.
- Memory outputs: mem_en/mem_we/mem_addr/mem_wdata are registered and driven in the cycle after the grant or video slot. mem_en=0 when no access is issued.
- Read tags:
  - A 2-bit tag (VID, PHY, LD) travels in a shift pipeline of depth MEM_LAT+1.
  - The matching rvalid/rdata, or the world_pixel update, appears MEM_LAT+1 cycles after acceptance.
  - Loader writes carry no tag and produce no rvalid.
- world_pixel holds its value until the next video read returns. It is forced to 0 on the first tick with video_on=0, and stays 0 through blanking.
- A new pixel_tick arriving while a video read is still in the pipeline is legal. Both reads complete in order.

Optional Feature:
- Macro: WORLD_ARB_PERF_EN
- Defined:
  - Adds output ports phy_wait_cnt[15:0] and ld_wait_cnt[15:0].
  - Each counter increments every cycle its req is high without gnt, and saturates at 16'hFFFF.
  - Both counters clear on reset or on a one-cycle input perf_clr.
- Undefined: these ports and the counter logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package world_pkg:
  - MAP_W, MAP_H, ADDR_W, and the 2-bit read tag enum (TAG_NONE, TAG_VID, TAG_PHY, TAG_LD).
  - The cell-address function (row, col) -> addr, reused by the physics block.
- One sub-module, rr_arb2: 2-requester round-robin arbiter with a block input that suppresses grants in the video slot.

Test Plan:
- Reset check: hold sys_rst=0, then release, with no requests -> all outputs 0 and mem_en stays 0.
- Video fetch: video_on=1, row=8, col=12, tick -> mem_addr=323 and mem_en=1 at tick+1; BRAM model returns 8'h5A -> world_pixel=8'h5A at tick+2 (MEM_LAT=1).
- Contention: ticks every 4 cycles, video_on=1, phy_req and ld_req held high -> tick cycles grant nobody; the 3 free cycles grant phy, ld, phy, then the next window starts with ld.
- Blanking: video_on=0 with ld_req and ld_we=1, addr 19199, data 8'hC3 -> ld_gnt even on the tick cycle; write issued; world_pixel=0.
- Physics read: phy_req, addr 100 -> phy_gnt at cycle t, phy_rvalid at t+2 with model data; no ld_rvalid.
- Reset mid-read: assert sys_rst low one cycle after phy_gnt -> phy_rvalid never asserts; after release, a contested request grants phy first.

Source files
------------

// File: rtl/world_pkg.sv
// rtl/world_pkg.sv - world map geometry, read tag type and cell-address helper
// Shared by the memory arbiter and the physics block.
package world_pkg;

  localparam int MAP_W  = 160;
  localparam int MAP_H  = 120;
  localparam int ADDR_W = 15;
  localparam int SCR_W  = 640;
  localparam int SCR_H  = 480;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_PHY  = 2'd2,
    TAG_LD   = 2'd3
  } tag_t;

  // Off-screen coordinates map to the last cell instead of wrapping into the map.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] row, input logic [9:0] col);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    r = ADDR_W'(row[9:2]);
    c = ADDR_W'(col[9:2]);
    if (row >= 10'(SCR_H) || col >= 10'(SCR_W))
      return ADDR_W'(MAP_W * MAP_H - 1);
    return r * ADDR_W'(MAP_W) + c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a grant-blocking input
// Grants are combinational; the pointer moves only when both requesters contend.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic block,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;  // 0 favours req0 on the next contested cycle
  logic contested;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    contested = !block && req0 && req1;
    if (!block) begin
      if (contested) begin
        gnt0 = !ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (contested)
      ptr <= !ptr;
  end

endmodule

// File: rtl/world_mem_arbiter.sv
// rtl/world_mem_arbiter.sv - world-map BRAM arbiter: fixed video slot, round-robin game slots
// Optional wait counters are built when WORLD_ARB_PERF_EN is defined.
module world_mem_arbiter
  import world_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pixel_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_row,
  input  logic [9:0]        pixel_column,
  output logic [7:0]        world_pixel,
  input  logic              phy_req,
  input  logic [ADDR_W-1:0] phy_addr,
  output logic              phy_gnt,
  output logic              phy_rvalid,
  output logic [7:0]        phy_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [7:0]        ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
`ifdef WORLD_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       phy_wait_cnt,
  output logic [15:0]       ld_wait_cnt
`endif
);

  logic              video_slot;
  logic [ADDR_W-1:0] vid_addr;
  tag_t              tag_in;
  tag_t              tag_q [0:MEM_LAT];
  tag_t              ret_tag;
  logic [7:0]        pix_q;

  assign video_slot = pixel_tick && video_on;
  assign vid_addr   = cell_addr(pixel_row, pixel_column);

  rr_arb2 u_arb (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .block (video_slot),
    .req0  (phy_req),
    .req1  (ld_req),
    .gnt0  (phy_gnt),
    .gnt1  (ld_gnt)
  );

  always_comb begin
    tag_in = TAG_NONE;
    if (video_slot)
      tag_in = TAG_VID;
    else if (phy_gnt)
      tag_in = TAG_PHY;
    else if (ld_gnt && !ld_we)
      tag_in = TAG_LD;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= video_slot || phy_gnt || ld_gnt;
      mem_we <= ld_gnt && ld_we;
      if (video_slot) begin
        mem_addr <= vid_addr;
      end else if (phy_gnt) begin
        mem_addr <= phy_addr;
      end else if (ld_gnt) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
      end
    end
  end

  // Tag reaches the last stage in the same cycle the BRAM presents its read data.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i <= MEM_LAT; i++)
        tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i <= MEM_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret_tag    = tag_q[MEM_LAT];
  assign phy_rvalid = (ret_tag == TAG_PHY);
  assign ld_rvalid  = (ret_tag == TAG_LD);
  assign phy_rdata  = phy_rvalid ? mem_rdata : 8'h00;
  assign ld_rdata   = ld_rvalid ? mem_rdata : 8'h00;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)
      pix_q <= 8'h00;
    else if (pixel_tick && !video_on)
      pix_q <= 8'h00;
    else if (ret_tag == TAG_VID)
      pix_q <= mem_rdata;
  end

  // Returning video data is forwarded so the colorizer sees it on arrival.
  assign world_pixel = (ret_tag == TAG_VID) ? mem_rdata : pix_q;

`ifdef WORLD_ARB_PERF_EN
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      phy_wait_cnt <= 16'h0000;
      ld_wait_cnt  <= 16'h0000;
    end else if (perf_clr) begin
      phy_wait_cnt <= 16'h0000;
      ld_wait_cnt  <= 16'h0000;
    end else begin
      if (phy_req && !phy_gnt && phy_wait_cnt != 16'hFFFF)
        phy_wait_cnt <= phy_wait_cnt + 16'd1;
      if (ld_req && !ld_gnt && ld_wait_cnt != 16'hFFFF)
        ld_wait_cnt <= ld_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_world_mem_arbiter.sv
// tb/tb_world_mem_arbiter.sv - self-checking bench for world_mem_arbiter
// Address table, directed corner sequences, then randomized traffic against a reference model.
module tb_world_mem_arbiter;
  import world_pkg::*;

  localparam int RET_LAT = 2;  // acceptance to rvalid for MEM_LAT=1

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              pixel_tick, video_on;
  logic [9:0]        pixel_row, pixel_column;
  logic [7:0]        world_pixel;
  logic              phy_req, phy_gnt, phy_rvalid;
  logic [ADDR_W-1:0] phy_addr;
  logic [7:0]        phy_rdata;
  logic              ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata, ld_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
`ifdef WORLD_ARB_PERF_EN
  logic              perf_clr = 1'b0;
  logic [15:0]       phy_wait_cnt, ld_wait_cnt;
`endif

  world_mem_arbiter #(.MEM_LAT(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column), .world_pixel(world_pixel),
    .phy_req(phy_req), .phy_addr(phy_addr), .phy_gnt(phy_gnt), .phy_rvalid(phy_rvalid),
    .phy_rdata(phy_rdata), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef WORLD_ARB_PERF_EN
    , .perf_clr(perf_clr), .phy_wait_cnt(phy_wait_cnt), .ld_wait_cnt(ld_wait_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Single-port BRAM with one cycle of read latency
  logic [7:0] bram [0:32767];
  always @(posedge sys_clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  function automatic logic [7:0] init_val(input int a);
    if (a == 323) return 8'h5A;
    return 8'(a ^ (a >> 7) ^ 8'h3C);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    pixel_tick = 1'b0; video_on = 1'b0; pixel_row = '0; pixel_column = '0;
    phy_req = 1'b0; phy_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    sys_rst = 1'b0;
    repeat (2) step();
    sys_rst = 1'b1;
    step();
  endtask

  typedef struct packed {
    logic [9:0]  row;
    logic [9:0]  col;
    logic [14:0] addr;
    logic [7:0]  pix;
  } vec_t;
  vec_t vt [10];

  // Reference model state for the randomized phase
  typedef struct {
    int         due;
    int         kind;  // 1 video, 2 physics, 3 loader
    logic [7:0] data;
  } ret_t;
  ret_t       q [$];
  logic [7:0] ref_mem [0:32767];
  bit         turn_ld, phy_taken, ld_taken, pen, pwe;
  int         paddr, cyc, tgap;
  logic [7:0] pwdata, wp_hold;

  task automatic rand_cycle(input bit stim);
    bit vid, ep, el, erp, erl, ewv;
    logic [7:0] dp, dl, dv, wp_now;
    int a;
    ret_t r;
    if (stim) begin
      if (tgap == 0) begin
        pixel_tick = 1'b1;
        tgap = $urandom_range(3, 6) - 1;
        if ($urandom_range(0, 3) == 0) video_on = !video_on;
        pixel_row = 10'($urandom_range(0, 511));
        pixel_column = 10'($urandom_range(0, 703));
      end else begin
        pixel_tick = 1'b0;
        tgap--;
      end
      if (!phy_req || phy_taken) begin
        phy_req = ($urandom_range(0, 2) != 0);
        phy_addr = 15'($urandom_range(0, 19199));
      end
      if (!ld_req || ld_taken) begin
        ld_req = ($urandom_range(0, 2) != 0);
        ld_we = 1'($urandom_range(0, 1));
        ld_addr = 15'($urandom_range(0, 19199));
        ld_wdata = 8'($urandom_range(0, 255));
      end
    end else begin
      pixel_tick = 1'b0; phy_req = 1'b0; ld_req = 1'b0;
    end
    @(negedge sys_clk);
    vid = pixel_tick && video_on;
    ep = 1'b0; el = 1'b0;
    if (!vid) begin
      if (phy_req && ld_req) begin
        if (turn_ld) el = 1'b1; else ep = 1'b1;
        turn_ld = !turn_ld;
      end else begin
        ep = phy_req; el = ld_req;
      end
    end
    chk("rnd_phy_gnt", phy_gnt, ep);
    chk("rnd_ld_gnt", ld_gnt, el);
    phy_taken = ep; ld_taken = el;
    chk("rnd_mem_en", mem_en, pen);
    if (pen) begin
      chk("rnd_mem_addr", mem_addr, paddr);
      chk("rnd_mem_we", mem_we, pwe);
      if (pwe) chk("rnd_mem_wdata", mem_wdata, pwdata);
    end
    erp = 0; erl = 0; ewv = 0; dp = 0; dl = 0; dv = 0;
    while (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.kind == 1) begin ewv = 1; dv = r.data; end
      if (r.kind == 2) begin erp = 1; dp = r.data; end
      if (r.kind == 3) begin erl = 1; dl = r.data; end
    end
    chk("rnd_phy_rvalid", phy_rvalid, erp);
    chk("rnd_ld_rvalid", ld_rvalid, erl);
    if (erp) chk("rnd_phy_rdata", phy_rdata, dp);
    if (erl) chk("rnd_ld_rdata", ld_rdata, dl);
    wp_now = ewv ? dv : wp_hold;
    chk("rnd_world_pixel", world_pixel, wp_now);
    wp_hold = (pixel_tick && !video_on) ? 8'h00 : wp_now;
    pen = 1'b0; pwe = 1'b0;
    r.due = cyc + RET_LAT;
    if (vid) begin
      if (pixel_row > 479 || pixel_column > 639) a = MAP_W * MAP_H - 1;
      else a = (int'(pixel_row) / 4) * MAP_W + int'(pixel_column) / 4;
      r.kind = 1; r.data = ref_mem[a]; q.push_back(r);
      pen = 1'b1; paddr = a;
    end else if (ep) begin
      r.kind = 2; r.data = ref_mem[phy_addr]; q.push_back(r);
      pen = 1'b1; paddr = int'(phy_addr);
    end else if (el) begin
      pen = 1'b1; paddr = int'(ld_addr); pwe = ld_we; pwdata = ld_wdata;
      if (ld_we) ref_mem[ld_addr] = ld_wdata;
      else begin r.kind = 3; r.data = ref_mem[ld_addr]; q.push_back(r); end
    end
    cyc++;
    step();
  endtask

  logic [1:0] cexp [8];

  initial begin
    for (int i = 0; i < 32768; i++) bram[i] = init_val(i);
    idle();
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_gnt", {phy_gnt, ld_gnt}, 2'b00);
    chk("rst_rvalid", {phy_rvalid, ld_rvalid}, 2'b00);
    chk("rst_rdata", {phy_rdata, ld_rdata}, 16'h0000);
    chk("rst_world_pixel", world_pixel, 8'h00);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 25'h0);
    step();
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("post_rst_mem_en", mem_en, 1'b0);
      chk("post_rst_pixel", world_pixel, 8'h00);
      step();
    end

    vt[0] = '{10'd8,   10'd12,  15'd323,   8'h5A};
    vt[1] = '{10'd0,   10'd0,   15'd0,     init_val(0)};
    vt[2] = '{10'd479, 10'd639, 15'd19199, init_val(19199)};
    vt[3] = '{10'd480, 10'd0,   15'd19199, init_val(19199)};
    vt[4] = '{10'd0,   10'd640, 15'd19199, init_val(19199)};
    vt[5] = '{10'd1023,10'd1023,15'd19199, init_val(19199)};
    vt[6] = '{10'd4,   10'd4,   15'd161,   init_val(161)};
    vt[7] = '{10'd100, 10'd200, 15'd4050,  init_val(4050)};
    vt[8] = '{10'd3,   10'd3,   15'd0,     init_val(0)};
    vt[9] = '{10'd479, 10'd0,   15'd19040, init_val(19040)};
    for (int i = 0; i < 10; i++) begin
      pixel_tick = 1'b1; video_on = 1'b1;
      pixel_row = vt[i].row; pixel_column = vt[i].col;
      step();
      pixel_tick = 1'b0;
      @(negedge sys_clk);
      chk("vid_mem_en", mem_en, 1'b1);
      chk("vid_mem_we", mem_we, 1'b0);
      chk("vid_mem_addr", mem_addr, vt[i].addr);
      step();
      @(negedge sys_clk);
      chk("vid_world_pixel", world_pixel, vt[i].pix);
      step();
    end

    // Contention: tick every 4 cycles, both requesters always asking
    do_reset();
    cexp = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
    video_on = 1'b1; phy_req = 1'b1; ld_req = 1'b1; phy_addr = 15'd5; ld_addr = 15'd6;
    for (int c = 0; c < 8; c++) begin
      pixel_tick = (c % 4 == 0);
      @(negedge sys_clk);
      chk("contend_gnt", {ld_gnt, phy_gnt}, cexp[c]);
      step();
    end
    idle();
    repeat (3) step();

    // Blanking tick still serves the loader and clears world_pixel
    pixel_tick = 1'b1; video_on = 1'b0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 15'd19199; ld_wdata = 8'hC3;
    @(negedge sys_clk);
    chk("blank_gnt", {ld_gnt, phy_gnt}, 2'b10);
    step();
    idle();
    @(negedge sys_clk);
    chk("blank_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 15'd19199, 8'hC3});
    chk("blank_world_pixel", world_pixel, 8'h00);
    step();
    @(negedge sys_clk);
    chk("blank_no_rvalid", ld_rvalid, 1'b0);
    step();

    // Physics read latency
    phy_req = 1'b1; phy_addr = 15'd100;
    @(negedge sys_clk);
    chk("phy_gnt", phy_gnt, 1'b1);
    step();
    phy_req = 1'b0;
    @(negedge sys_clk);
    chk("phy_early_rvalid", phy_rvalid, 1'b0);
    chk("phy_mem_addr", {mem_en, mem_addr}, {1'b1, 15'd100});
    step();
    @(negedge sys_clk);
    chk("phy_rvalid", {phy_rvalid, ld_rvalid}, 2'b10);
    chk("phy_rdata", phy_rdata, init_val(100));
    step();

    // Reset one cycle after grant drops the read
    phy_req = 1'b1; phy_addr = 15'd200;
    @(negedge sys_clk);
    chk("rst_mid_gnt", phy_gnt, 1'b1);
    step();
    phy_req = 1'b0; sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("rst_mid_no_rvalid", phy_rvalid, 1'b0);
      step();
    end
    sys_rst = 1'b1;
    phy_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_ptr_phy", {ld_gnt, phy_gnt}, 2'b01);
    step();
    idle();
    repeat (3) step();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
    ref_mem[19199] = 8'hC3;
    q.delete();
    turn_ld = 0; phy_taken = 0; ld_taken = 0; pen = 0; pwe = 0;
    paddr = 0; pwdata = 0; wp_hold = 0; cyc = 0; tgap = 0;
    video_on = 1'b1;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 4; i++) rand_cycle(1'b0);
    chk("rnd_all_returned", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
